// File: rtl/uart_core.sv
// 8N1 UART transceiver: baud timing, RX deserializer + RX FIFO,
// TX FIFO + TX serializer, and a loopback/echo mode mux.
//
// Stream handshake (both byte streams): a byte moves on a rising clk edge
// where valid and ready are both high; data is held stable while valid is
// high and the byte has not yet been accepted.

// Synchronous FIFO with an extra pointer bit to separate full from empty.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         do_wr, do_rd;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so push-on-full is allowed then.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rptr_q[AW-1:0]];

  // Next pointer values; both wrap naturally through the extra bit.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + (AW+1)'(1);
    if (do_rd) rptr_d = rptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q[AW-1:0]] <= wr_data;
  end
endmodule

module uart_core #(
  parameter     DEVICE     = "7SERIES",
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic       uart_ready,
  output logic [7:0] uart_rd_data,
  output logic       uart_rd_valid,
  input  logic       uart_rd_ready,
  input  logic [7:0] uart_wr_data,
  input  logic       uart_wr_valid,
  output logic       uart_wr_ready,
  input  logic [1:0] uart_mode,
  input  logic       uart_rxd,
  output logic       uart_txd
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);

  if (DEVICE != "7SERIES") begin : g_bad_device
    $error("uart_core: only DEVICE \"7SERIES\" is supported");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_core: FIFO_DEPTH must be a power of two >= 4");
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [4:0]    rdy_cnt_q, rdy_cnt_d;
  logic          rxd_s1_q, rxd_s2_q;
  logic          loopback, echo, rx_in;
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_push_q, rx_pop, rx_empty, rx_full;
  logic          rx_overrun_q, rx_overrun_d;
  tx_state_t     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q, tx_fifo_data;
  logic          tx_ser_q, tx_last, tx_pop, tx_push, tx_empty, tx_full;
  logic          unused_flags;

  // Ready counter: bit 4 sets after 16 clocks out of reset and then holds.
  always_comb begin
    rdy_cnt_d = rdy_cnt_q;
    if (!rdy_cnt_q[4]) rdy_cnt_d = rdy_cnt_q + 5'd1;
  end

  // Ready counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_cnt_q <= '0;
    else     rdy_cnt_q <= rdy_cnt_d;
  end

  assign uart_ready    = rdy_cnt_q[4];
  assign uart_wr_ready = uart_ready && !tx_full;
  assign uart_rd_valid = !rx_empty;
  assign rx_pop        = uart_rd_ready && uart_rd_valid;
  assign tx_push       = uart_wr_valid && uart_wr_ready;

  // Two-flop synchronizer for the asynchronous serial input, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      rxd_s1_q <= uart_rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // Mode mux; 2'b11 falls through to normal operation.
  assign loopback = (uart_mode == 2'b01);
  assign echo     = (uart_mode == 2'b10);
  assign rx_in    = loopback ? tx_ser_q : rxd_s2_q;
  assign uart_txd = loopback ? 1'b1 : (echo ? rxd_s2_q : tx_ser_q);

  // RX state machine: mid-bit sampling, LSB first, push on a good stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_push_q  <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_in) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_in, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rx_in) begin
              rx_push_q  <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_WAIT;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_WAIT: begin
          // Framing error: hold off until the line is back to idle.
          if (rx_in) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Sticky overrun: a received byte arrived with no room in the RX FIFO.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (rx_push_q && rx_full && !rx_pop) rx_overrun_d = 1'b1;
  end

  // Overrun register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overrun_q <= 1'b0;
    else     rx_overrun_q <= rx_overrun_d;
  end

  // The overrun flag is an internal probe point with no consumer.
  assign unused_flags = rx_overrun_q;

  uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .wr_en(rx_push_q), .wr_data(rx_sh_q),
    .rd_en(rx_pop), .rd_data(uart_rd_data),
    .empty(rx_empty), .full(rx_full)
  );

  uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .wr_en(tx_push), .wr_data(uart_wr_data),
    .rd_en(tx_pop), .rd_data(tx_fifo_data),
    .empty(tx_empty), .full(tx_full)
  );

  // Pop from IDLE, or at the end of a stop bit so frames run back to back.
  assign tx_last = (tx_cnt_q == BIT_LAST);
  assign tx_pop  = !tx_empty && ((tx_state_q == TX_IDLE) ||
                                 ((tx_state_q == TX_STOP) && tx_last));

  // TX state machine: start, 8 data bits LSB first, stop; registered line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_ser_q   <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          tx_ser_q <= 1'b1;
          if (tx_pop) begin
            tx_sh_q    <= tx_fifo_data;
            tx_ser_q   <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_ser_q   <= tx_sh_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_ser_q   <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_ser_q <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_sh_q    <= tx_fifo_data;
              tx_ser_q   <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core with a short bit period (16 clocks)
// and 4-entry FIFOs so every scenario fits in a few thousand cycles.
module tb_uart_core;
  localparam int CLK_FREQ = 16000000;
  localparam int BAUD     = 1000000;
  localparam int BIT      = 16;
  localparam int DEPTH    = 4;

  logic       clk, rst;
  logic       uart_ready, uart_rd_valid, uart_rd_ready;
  logic [7:0] uart_rd_data, uart_wr_data;
  logic       uart_wr_valid, uart_wr_ready;
  logic [1:0] uart_mode;
  logic       uart_rxd, uart_txd;

  uart_core #(
    .DEVICE("7SERIES"), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .uart_ready(uart_ready),
    .uart_rd_data(uart_rd_data), .uart_rd_valid(uart_rd_valid), .uart_rd_ready(uart_rd_ready),
    .uart_wr_data(uart_wr_data), .uart_wr_valid(uart_wr_valid), .uart_wr_ready(uart_wr_ready),
    .uart_mode(uart_mode), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;       // serial byte driven on rxd
    logic       stop;       // value driven in the stop-bit slot
    logic       exp_valid;  // byte expected in RX FIFO
    logic [7:0] exp_data;
  } rx_vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: one 8N1 frame on rxd, entered and left on a falling clk edge.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = 1'b1;
  endtask

  // Driver: offer one byte on the write stream.
  task automatic write_byte(input logic [7:0] d);
    int t;
    t = 0;
    while (!uart_wr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("wr_ready_%02h", d), 32'(uart_wr_ready), 32'd1);
    uart_wr_data  = d;
    uart_wr_valid = 1'b1;
    @(negedge clk);
    uart_wr_valid = 1'b0;
  endtask

  // Scoreboard: pop one byte from the read stream, compare with exp_q front.
  task automatic pop_check(input string name);
    int t;
    logic [7:0] e;
    t = 0;
    while (!uart_rd_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check($sformatf("%s_valid", name), 32'(uart_rd_valid), 32'd1);
    if (uart_rd_valid) begin
      check($sformatf("%s_data", name), 32'(uart_rd_data), 32'(e));
      uart_rd_ready = 1'b1;
      @(negedge clk);
      uart_rd_ready = 1'b0;
    end
  endtask

  rx_vec_t    vecs[6];
  logic [7:0] burst[5];
  logic [19:0] tx_bits;
  int rise, bad, good, t;
  logic d1, d2, v;
  logic [9:0] f;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[3] = '{8'hC3, 1'b0, 1'b0, 8'h00};  // framing error: dropped
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81};
    burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst = 1'b1; uart_rxd = 1'b1; uart_rd_ready = 1'b0;
    uart_wr_valid = 1'b0; uart_wr_data = 8'h00; uart_mode = 2'b00;
    idle(3);
    check("rst_ready",    32'(uart_ready),    32'd0);
    check("rst_txd",      32'(uart_txd),      32'd1);
    check("rst_rd_valid", 32'(uart_rd_valid), 32'd0);
    check("rst_wr_ready", 32'(uart_wr_ready), 32'd0);
    check("rst_rd_data",  32'(uart_rd_data),  32'd0);

    // Reset release: ready rises after exactly 16 edges.
    rst = 1'b0;
    rise = 0; bad = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (rise == 0 && uart_ready) rise = k;
      if (uart_txd !== 1'b1) bad++;
      if (uart_wr_ready && !uart_ready) bad++;
    end
    check("ready_rise_cycle", 32'(rise), 32'd16);
    check("release_txd_wr_ready", 32'(bad), 32'd0);
    check("release_rd_valid", 32'(uart_rd_valid), 32'd0);

    // Short low pulse on rxd is a glitch, not a start bit.
    uart_rxd = 1'b0;
    idle(5);
    uart_rxd = 1'b1;
    idle(40);
    check("glitch_no_push", 32'(uart_rd_valid), 32'd0);

    // Table of single frames, each followed by idle line.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      idle(20);
      if (vecs[i].exp_valid) begin
        exp_q.push_back(vecs[i].exp_data);
        pop_check($sformatf("rx_vec%0d", i));
      end else begin
        check($sformatf("rx_vec%0d_drop", i), 32'(uart_rd_valid), 32'd0);
      end
    end

    // Back-to-back frames, FIFO_DEPTH+1 of them, no reads: last is dropped.
    for (int i = 0; i < 5; i++) send_frame(burst[i], 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(burst[i]);
    idle(30);
    for (int i = 0; i < 4; i++) pop_check($sformatf("burst%0d", i));
    idle(2);
    check("overrun_dropped", 32'(uart_rd_valid), 32'd0);

    // TX: two frames back to back, every bit exactly BIT clocks wide.
    write_byte(8'h55);
    write_byte(8'hA3);
    t = 0;
    while (uart_txd && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", 32'(uart_txd), 32'd0);
    tx_bits = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 20; b++) begin
      good = 0;
      for (int c = 0; c < BIT; c++) begin
        if (uart_txd === tx_bits[b]) good++;
        @(negedge clk);
      end
      check($sformatf("tx_bit%0d", b), 32'(good), BIT);
    end
    idle(5);
    check("tx_idle_after", 32'(uart_txd), 32'd1);

    // Local loopback: bytes return through RX, txd pinned high.
    uart_mode = 2'b01;
    bad = 0;
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h5A);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    for (int c = 0; c < 3 * 10 * BIT + 60; c++) begin
      if (uart_txd !== 1'b1) bad++;
      @(negedge clk);
    end
    check("loop_txd_high", 32'(bad), 32'd0);
    for (int i = 0; i < 3; i++) pop_check($sformatf("loop%0d", i));
    uart_mode = 2'b00;
    idle(5);

    // Remote echo: txd follows rxd two clocks later; RX still receives.
    uart_mode = 2'b10;
    idle(3);
    f = {1'b1, 8'h96, 1'b0};
    d1 = 1'b1; d2 = 1'b1; bad = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BIT; c++) begin
        v = f[i];
        uart_rxd = v;
        d2 = d1;
        d1 = v;
        @(negedge clk);
        if (uart_txd !== d2) bad++;
      end
    end
    uart_rxd = 1'b1;
    check("echo_follow", 32'(bad), 32'd0);
    idle(20);
    exp_q.push_back(8'h96);
    pop_check("echo_rx");
    uart_mode = 2'b00;
    idle(5);

    // Reset mid-TX-frame with data pending in both FIFOs.
    send_frame(8'h77, 1'b1);
    idle(20);
    check("pre_rst_rd_valid", 32'(uart_rd_valid), 32'd1);
    write_byte(8'h12);
    write_byte(8'h34);
    t = 0;
    while (uart_txd && t < 100) begin
      @(negedge clk);
      t++;
    end
    idle(20);
    check("pre_rst_txd_low", 32'(uart_txd), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_txd",      32'(uart_txd),      32'd1);
    check("rst_mid_rd_valid", 32'(uart_rd_valid), 32'd0);
    check("rst_mid_ready",    32'(uart_ready),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    check("post_rst_ready",    32'(uart_ready),    32'd1);
    check("post_rst_wr_ready", 32'(uart_wr_ready), 32'd1);
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (uart_txd !== 1'b1) bad++;
      if (uart_rd_valid) bad++;
      @(negedge clk);
    end
    check("post_rst_fifos_empty", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
